// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-addressed on-chip memory.
// Pipelined address/data phases, WAIT_STATES wait cycles per OKAY transfer,
// and a two-cycle ERROR response for illegal size, alignment or address range.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no data phase in progress, bus ready
// WAIT  | OKAY transfer captured, inserting wait cycles (hreadyout low)
// DATA  | completing cycle of an OKAY transfer (write commits at its end)
// ERR1  | first ERROR cycle (hreadyout low, hresp high)
// ERR2  | second ERROR cycle (hreadyout high, hresp high)

module ahb_slave_mem #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  WS = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state;
    logic [2:0]    wait_cnt;
    logic [AW-1:0] data_idx;
    logic          data_write;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [32:0]   offset;
    logic          accept;
    logic          addr_err;

    // Address-phase decode: the 33-bit offset carries a borrow when haddr is
    // below BASE_ADDR, so one zero test on the upper bits covers both range ends.
    always_comb begin
        offset   = {1'b0, haddr} - {1'b0, BASE_ADDR};
        accept   = hreadyout && hsel && htrans[1];
        addr_err = (hsize != 3'b010)
                || (offset[1:0] != 2'b00)
                || (offset[32:AW+2] != '0);
    end

    // Transfer sequencing; hreadyout/hresp are registered alongside the state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            hreadyout  <= 1'b1;
            hresp      <= 1'b0;
            data_idx   <= '0;
            data_write <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt <= 3'd1) begin
                        state     <= ST_DATA;
                        wait_cnt  <= '0;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                // IDLE, DATA and ERR2 all drive hreadyout high, so the next
                // address phase is evaluated here; unused encodings recover too.
                default: begin
                    if (accept) begin
                        data_idx   <= offset[AW+1:2];
                        data_write <= hwrite;
                        if (addr_err) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else if (WS != 3'd0) begin
                            state     <= ST_WAIT;
                            wait_cnt  <= WS;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b0;
                        end else begin
                            state     <= ST_DATA;
                            hreadyout <= 1'b1;
                            hresp     <= 1'b0;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Memory array: cleared by reset, written only at the end of a write DATA cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (state == ST_DATA && data_write) begin
            mem[data_idx] <= hwdata;
        end
    end

    // Read data is taken straight from the array so a write committed at the
    // edge that opens a read's data phase is already visible.
    always_comb begin
        hrdata = '0;
        if (state == ST_DATA && !data_write) begin
            hrdata = mem[data_idx];
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances with 0, 3 and 1 wait
// states share one bus; sel picks which one is addressed and observed.

module tb_ahb_slave_mem;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 256;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [1:0]  sel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    logic [31:0] rdata_0, rdata_3, rdata_1, hrdata_m;
    logic        rdy_0, rdy_3, rdy_1, hready_m;
    logic        resp_0, resp_3, resp_1, hresp_m;

    int n_cmp = 0;
    int n_bad = 0;

    // phase table for the pipelined driver
    int          n_ph;
    logic [1:0]  p_trans [16];
    logic        p_write [16];
    logic [2:0]  p_size  [16];
    logic [31:0] p_addr  [16];
    logic [31:0] p_wdata [16];
    int          e_wait  [16];
    logic        e_resp  [16];
    logic [31:0] e_rdata [16];
    int          obs_wait  [16];
    logic        obs_resp  [16];
    logic        obs_low   [16];
    logic [31:0] obs_rdata [16];

    always #5 clk = ~clk;

    ahb_slave_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut_ws0 (
        .clk(clk), .n_rst(n_rst), .hsel(sel == 2'd0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(rdata_0),
        .hreadyout(rdy_0), .hresp(resp_0));

    ahb_slave_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE)) dut_ws3 (
        .clk(clk), .n_rst(n_rst), .hsel(sel == 2'd1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(rdata_3),
        .hreadyout(rdy_3), .hresp(resp_3));

    ahb_slave_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .BASE_ADDR(BASE)) dut_ws1 (
        .clk(clk), .n_rst(n_rst), .hsel(sel == 2'd2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(rdata_1),
        .hreadyout(rdy_1), .hresp(resp_1));

    always_comb begin
        case (sel)
            2'd0:    begin hrdata_m = rdata_0; hready_m = rdy_0; hresp_m = resp_0; end
            2'd1:    begin hrdata_m = rdata_3; hready_m = rdy_3; hresp_m = resp_3; end
            default: begin hrdata_m = rdata_1; hready_m = rdy_1; hresp_m = resp_1; end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_ph(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input int ew, input logic er, input logic [31:0] ed);
        if (n_ph < 16) begin
            p_trans[n_ph] = tr; p_write[n_ph] = wr; p_size[n_ph] = sz;
            p_addr[n_ph] = ad;  p_wdata[n_ph] = wd;
            e_wait[n_ph] = ew;  e_resp[n_ph] = er;  e_rdata[n_ph] = ed;
            n_ph++;
        end
    endtask

    // Plays the phase table as a master would: each address phase is held
    // until hreadyout is high, hwdata follows in the completing cycle.
    task automatic run_pipe();
        int w;
        htrans = p_trans[0]; hwrite = p_write[0]; hsize = p_size[0]; haddr = p_addr[0];
        tick();
        for (int i = 1; i <= n_ph; i++) begin
            w = 0;
            obs_low[i-1] = 1'b0;
            while (hready_m !== 1'b1 && w < 20) begin
                obs_low[i-1] = obs_low[i-1] | hresp_m;
                tick();
                w++;
            end
            obs_wait[i-1]  = (w >= 20) ? 99 : w;
            obs_resp[i-1]  = hresp_m;
            obs_rdata[i-1] = hrdata_m;
            hwdata = p_wdata[i-1];
            if (i < n_ph) begin
                htrans = p_trans[i]; hwrite = p_write[i]; hsize = p_size[i]; haddr = p_addr[i];
            end else begin
                htrans = T_IDLE; hwrite = 1'b0; hsize = 3'b010;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (rdy_0 !== 1'b1)   begin n_bad++; $display("FAIL reset ws0 hreadyout: got %b want 1", rdy_0); end
        n_cmp++; if (resp_0 !== 1'b0)  begin n_bad++; $display("FAIL reset ws0 hresp: got %b want 0", resp_0); end
        n_cmp++; if (rdata_0 !== 32'h0) begin n_bad++; $display("FAIL reset ws0 hrdata: got %h want 0", rdata_0); end
        n_cmp++; if (rdy_3 !== 1'b1)   begin n_bad++; $display("FAIL reset ws3 hreadyout: got %b want 1", rdy_3); end
        n_cmp++; if (resp_3 !== 1'b0)  begin n_bad++; $display("FAIL reset ws3 hresp: got %b want 0", resp_3); end
        n_cmp++; if (rdata_3 !== 32'h0) begin n_bad++; $display("FAIL reset ws3 hrdata: got %h want 0", rdata_3); end
        n_cmp++; if (rdy_1 !== 1'b1)   begin n_bad++; $display("FAIL reset ws1 hreadyout: got %b want 1", rdy_1); end
        n_cmp++; if (resp_1 !== 1'b0)  begin n_bad++; $display("FAIL reset ws1 hresp: got %b want 0", resp_1); end
        n_cmp++; if (rdata_1 !== 32'h0) begin n_bad++; $display("FAIL reset ws1 hrdata: got %h want 0", rdata_1); end
    endtask

    task automatic test_write_read();
        sel = 2'd0; n_ph = 0;
        add_ph(T_NONSEQ, 1'b1, 3'b010, BASE + 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h10, 32'h0,         0, 1'b0, 32'hDEAD_BEEF);
        add_ph(T_SEQ,    1'b0, 3'b010, BASE + 32'h14, 32'h0,         0, 1'b0, 32'h0);
        run_pipe();
        for (int i = 0; i < n_ph; i++) begin
            n_cmp++; if (obs_wait[i] !== e_wait[i])   begin n_bad++; $display("FAIL write_read[%0d] wait: got %0d want %0d", i, obs_wait[i], e_wait[i]); end
            n_cmp++; if (obs_low[i] !== e_resp[i])    begin n_bad++; $display("FAIL write_read[%0d] low-cycle hresp: got %b want %b", i, obs_low[i], e_resp[i]); end
            n_cmp++; if (obs_resp[i] !== e_resp[i])   begin n_bad++; $display("FAIL write_read[%0d] hresp: got %b want %b", i, obs_resp[i], e_resp[i]); end
            n_cmp++; if (obs_rdata[i] !== e_rdata[i]) begin n_bad++; $display("FAIL write_read[%0d] hrdata: got %h want %h", i, obs_rdata[i], e_rdata[i]); end
        end
    endtask

    task automatic test_wait_states();
        sel = 2'd1; n_ph = 0;
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h20,  32'h0,         3, 1'b0, 32'h0);
        add_ph(T_NONSEQ, 1'b1, 3'b010, BASE + 32'h30,  32'h0BAD_F00D, 3, 1'b0, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h30,  32'h0,         3, 1'b0, 32'h0BAD_F00D);
        add_ph(T_NONSEQ, 1'b1, 3'b010, BASE + 32'h400, 32'h1111_2222, 1, 1'b1, 32'h0);
        run_pipe();
        for (int i = 0; i < n_ph; i++) begin
            n_cmp++; if (obs_wait[i] !== e_wait[i])   begin n_bad++; $display("FAIL wait_states[%0d] wait: got %0d want %0d", i, obs_wait[i], e_wait[i]); end
            n_cmp++; if (obs_low[i] !== e_resp[i])    begin n_bad++; $display("FAIL wait_states[%0d] low-cycle hresp: got %b want %b", i, obs_low[i], e_resp[i]); end
            n_cmp++; if (obs_resp[i] !== e_resp[i])   begin n_bad++; $display("FAIL wait_states[%0d] hresp: got %b want %b", i, obs_resp[i], e_resp[i]); end
            n_cmp++; if (obs_rdata[i] !== e_rdata[i]) begin n_bad++; $display("FAIL wait_states[%0d] hrdata: got %h want %h", i, obs_rdata[i], e_rdata[i]); end
        end
    endtask

    task automatic test_out_of_range();
        sel = 2'd0; n_ph = 0;
        add_ph(T_NONSEQ, 1'b1, 3'b010, BASE + 32'h400, 32'h1234_5678, 1, 1'b1, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h3FC, 32'h0,         0, 1'b0, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE,           32'h0,         0, 1'b0, 32'h0);
        run_pipe();
        for (int i = 0; i < n_ph; i++) begin
            n_cmp++; if (obs_wait[i] !== e_wait[i])   begin n_bad++; $display("FAIL out_of_range[%0d] wait: got %0d want %0d", i, obs_wait[i], e_wait[i]); end
            n_cmp++; if (obs_low[i] !== e_resp[i])    begin n_bad++; $display("FAIL out_of_range[%0d] low-cycle hresp: got %b want %b", i, obs_low[i], e_resp[i]); end
            n_cmp++; if (obs_resp[i] !== e_resp[i])   begin n_bad++; $display("FAIL out_of_range[%0d] hresp: got %b want %b", i, obs_resp[i], e_resp[i]); end
            n_cmp++; if (obs_rdata[i] !== e_rdata[i]) begin n_bad++; $display("FAIL out_of_range[%0d] hrdata: got %h want %h", i, obs_rdata[i], e_rdata[i]); end
        end
    endtask

    task automatic test_bad_access();
        sel = 2'd0; n_ph = 0;
        add_ph(T_NONSEQ, 1'b1, 3'b010, BASE + 32'h22,  32'hBAD0_0001, 1, 1'b1, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h20,  32'h0,         0, 1'b0, 32'h0);
        add_ph(T_NONSEQ, 1'b1, 3'b000, BASE + 32'h24,  32'hBAD0_0002, 1, 1'b1, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h24,  32'h0,         0, 1'b0, 32'h0);
        add_ph(T_NONSEQ, 1'b1, 3'b010, BASE - 32'h4,   32'hBAD0_0003, 1, 1'b1, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h3FC, 32'h0,         0, 1'b0, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b001, BASE + 32'h10,  32'h0,         1, 1'b1, 32'h0);
        run_pipe();
        for (int i = 0; i < n_ph; i++) begin
            n_cmp++; if (obs_wait[i] !== e_wait[i])   begin n_bad++; $display("FAIL bad_access[%0d] wait: got %0d want %0d", i, obs_wait[i], e_wait[i]); end
            n_cmp++; if (obs_low[i] !== e_resp[i])    begin n_bad++; $display("FAIL bad_access[%0d] low-cycle hresp: got %b want %b", i, obs_low[i], e_resp[i]); end
            n_cmp++; if (obs_resp[i] !== e_resp[i])   begin n_bad++; $display("FAIL bad_access[%0d] hresp: got %b want %b", i, obs_resp[i], e_resp[i]); end
            n_cmp++; if (obs_rdata[i] !== e_rdata[i]) begin n_bad++; $display("FAIL bad_access[%0d] hrdata: got %h want %h", i, obs_rdata[i], e_rdata[i]); end
        end
    endtask

    task automatic test_back_to_back();
        sel = 2'd2; n_ph = 0;
        add_ph(T_NONSEQ, 1'b1, 3'b010, BASE + 32'h40, 32'd1, 1, 1'b0, 32'h0);
        add_ph(T_SEQ,    1'b1, 3'b010, BASE + 32'h44, 32'd2, 1, 1'b0, 32'h0);
        add_ph(T_SEQ,    1'b1, 3'b010, BASE + 32'h48, 32'd3, 1, 1'b0, 32'h0);
        add_ph(T_SEQ,    1'b1, 3'b010, BASE + 32'h4C, 32'd4, 1, 1'b0, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h40, 32'h0, 1, 1'b0, 32'd1);
        add_ph(T_SEQ,    1'b0, 3'b010, BASE + 32'h44, 32'h0, 1, 1'b0, 32'd2);
        add_ph(T_BUSY,   1'b0, 3'b010, BASE + 32'h48, 32'h0, 0, 1'b0, 32'h0);
        add_ph(T_SEQ,    1'b0, 3'b010, BASE + 32'h48, 32'h0, 1, 1'b0, 32'd3);
        add_ph(T_SEQ,    1'b0, 3'b010, BASE + 32'h4C, 32'h0, 1, 1'b0, 32'd4);
        run_pipe();
        for (int i = 0; i < n_ph; i++) begin
            n_cmp++; if (obs_wait[i] !== e_wait[i])   begin n_bad++; $display("FAIL back_to_back[%0d] wait: got %0d want %0d", i, obs_wait[i], e_wait[i]); end
            n_cmp++; if (obs_low[i] !== e_resp[i])    begin n_bad++; $display("FAIL back_to_back[%0d] low-cycle hresp: got %b want %b", i, obs_low[i], e_resp[i]); end
            n_cmp++; if (obs_resp[i] !== e_resp[i])   begin n_bad++; $display("FAIL back_to_back[%0d] hresp: got %b want %b", i, obs_resp[i], e_resp[i]); end
            n_cmp++; if (obs_rdata[i] !== e_rdata[i]) begin n_bad++; $display("FAIL back_to_back[%0d] hrdata: got %h want %h", i, obs_rdata[i], e_rdata[i]); end
        end
    endtask

    task automatic test_reset_mid_transfer();
        sel = 2'd1;
        htrans = T_NONSEQ; hwrite = 1'b1; hsize = 3'b010; haddr = BASE + 32'h50;
        hwdata = 32'hA5A5_A5A5;
        tick();
        tick();
        n_cmp++; if (hready_m !== 1'b0) begin n_bad++; $display("FAIL reset_mid pre-reset hreadyout: got %b want 0", hready_m); end
        #2;
        n_rst = 1'b0;
        #1;
        n_cmp++; if (hready_m !== 1'b1)  begin n_bad++; $display("FAIL reset_mid hreadyout: got %b want 1", hready_m); end
        n_cmp++; if (hresp_m !== 1'b0)   begin n_bad++; $display("FAIL reset_mid hresp: got %b want 0", hresp_m); end
        n_cmp++; if (hrdata_m !== 32'h0) begin n_bad++; $display("FAIL reset_mid hrdata: got %h want 0", hrdata_m); end
        htrans = T_IDLE; hwrite = 1'b0;
        tick();
        n_rst = 1'b1;
        n_ph = 0;
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h50, 32'h0, 3, 1'b0, 32'h0);
        add_ph(T_NONSEQ, 1'b0, 3'b010, BASE + 32'h30, 32'h0, 3, 1'b0, 32'h0);
        run_pipe();
        for (int i = 0; i < n_ph; i++) begin
            n_cmp++; if (obs_wait[i] !== e_wait[i])   begin n_bad++; $display("FAIL reset_mid[%0d] wait: got %0d want %0d", i, obs_wait[i], e_wait[i]); end
            n_cmp++; if (obs_resp[i] !== e_resp[i])   begin n_bad++; $display("FAIL reset_mid[%0d] hresp: got %b want %b", i, obs_resp[i], e_resp[i]); end
            n_cmp++; if (obs_rdata[i] !== e_rdata[i]) begin n_bad++; $display("FAIL reset_mid[%0d] hrdata: got %h want %h", i, obs_rdata[i], e_rdata[i]); end
        end
    endtask

    initial begin
        n_rst  = 1'b0;
        sel    = 2'd0;
        haddr  = 32'h0;
        htrans = T_IDLE;
        hwrite = 1'b0;
        hsize  = 3'b010;
        hwdata = 32'h0;
        n_ph   = 0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        test_reset();
        tick();
        test_write_read();
        test_wait_states();
        test_out_of_range();
        test_bad_access();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
